// File: rtl/sine_dds_quarter.sv
// sine_dds_quarter: DDS sample source using a phase accumulator, a quarter-wave ROM
// with quadrant symmetry, and 8-bit amplitude scaling. Produces offset-binary samples.
module sine_dds_quarter #(
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned QADDR_W = 10,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic               clk50m,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] fword,
    input  logic [7:0]         amp,
    output logic [QADDR_W-1:0] rom_addr,
    input  logic [DATA_W-2:0]  rom_q,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_vld
);

    localparam int unsigned MAG_W   = DATA_W - 1;
    localparam int unsigned PROD_W  = MAG_W + 9;
    localparam int unsigned PIPE_W  = ROM_LAT + 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    logic [PHASE_W-1:0] phase;
    logic               ph_vld;
    logic [PIPE_W-1:0]  vpipe;
    logic [PIPE_W-1:0]  spipe;
    logic [PROD_W-1:0]  prod;
    logic               prod_vld;
    logic               prod_sign;

    logic [1:0]         quad_c;
    logic [QADDR_W-1:0] idx_c;
    logic [QADDR_W-1:0] addr_c;
    logic [8:0]         amp_p1_c;
    logic [DATA_W-1:0]  mag_c;

    // Quadrant decode: odd quadrants mirror the index, upper half is negative.
    always_comb begin
        quad_c   = phase[PHASE_W-1 -: 2];
        idx_c    = phase[PHASE_W-3 -: QADDR_W];
        addr_c   = quad_c[0] ? ~idx_c : idx_c;
        amp_p1_c = {1'b0, amp} + 9'd1;
        mag_c    = DATA_W'(prod >> 8);
    end

    // Phase accumulator; clear wins over enable.
    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            phase  <= '0;
            ph_vld <= 1'b0;
        end else if (phase_clr) begin
            phase  <= '0;
            ph_vld <= 1'b0;
        end else begin
            ph_vld <= en;
            if (en) begin
                phase <= phase + fword;
            end
        end
    end

    // ROM address register plus valid/sign delay line matching ROM latency.
    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            rom_addr <= '0;
            vpipe    <= '0;
            spipe    <= '0;
        end else begin
            rom_addr <= addr_c;
            spipe    <= {spipe[PIPE_W-2:0], quad_c[1]};
            if (phase_clr) begin
                vpipe <= '0;
            end else begin
                vpipe <= {vpipe[PIPE_W-2:0], ph_vld};
            end
        end
    end

    // Amplitude multiply on ROM data.
    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            prod      <= '0;
            prod_vld  <= 1'b0;
            prod_sign <= 1'b0;
        end else begin
            prod      <= PROD_W'(rom_q) * PROD_W'(amp_p1_c);
            prod_sign <= spipe[PIPE_W-1];
            prod_vld  <= phase_clr ? 1'b0 : vpipe[PIPE_W-1];
        end
    end

    // Offset-binary output; sample holds when no valid token arrives.
    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            sample     <= MID;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= prod_vld && !phase_clr;
            if (prod_vld && !phase_clr) begin
                sample <= prod_sign ? (MID - mag_c) : (MID + mag_c);
            end
        end
    end

endmodule

// File: tb/tb_sine_dds_quarter.sv
// Testbench for sine_dds_quarter: linear quarter-wave ROM model, table-driven pulses,
// and directed sequences for back-to-back, clear and reset corner cases.
module tb_sine_dds_quarter;

    logic        clk50m = 1'b0;
    logic        rst_n;
    logic        en;
    logic        phase_clr;
    logic [23:0] fword;
    logic [7:0]  amp;
    logic [9:0]  rom_addr;
    logic [14:0] rom_q;
    logic [15:0] sample;
    logic        sample_vld;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [23:0] fw;
        logic [7:0]  am;
        logic [9:0]  exp_addr;
        logic [15:0] exp_sample;
    } vec_t;

    vec_t vecs[8];

    sine_dds_quarter dut (
        .clk50m    (clk50m),
        .rst_n     (rst_n),
        .en        (en),
        .phase_clr (phase_clr),
        .fword     (fword),
        .amp       (amp),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .sample    (sample),
        .sample_vld(sample_vld)
    );

    always #10 clk50m = ~clk50m;

    function automatic logic [14:0] rom_val(input logic [9:0] a);
        int unsigned v;
        v = (int'(a) * 32767) / 1023;
        return 15'(v);
    endfunction

    // Registered-output ROM model, one clock latency.
    always @(posedge clk50m) rom_q <= rom_val(rom_addr);

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One en pulse; checks address, latency, sample value and single-cycle strobe.
    task automatic run_pulse(input string name, input logic [23:0] fw, input logic [7:0] am,
                             input logic [9:0] exp_addr, input logic [15:0] exp_sample);
        int lat;
        bit seen;
        fword = fw;
        amp   = am;
        en    = 1'b1;
        tick();
        en  = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            tick();
            lat++;
            if (lat == 1) check({name, " addr"}, 32'(rom_addr), 32'(exp_addr));
            if (sample_vld) seen = 1'b1;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " sample"}, 32'(sample), 32'(exp_sample));
        tick();
        check({name, " vld single"}, 32'(sample_vld), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int vcount;
        int first;
        int nvld;
        vecs[0] = '{24'h400000, 8'd255, 10'd1023, 16'hFFFF};
        vecs[1] = '{24'h400000, 8'd255, 10'd0,    16'h8000};
        vecs[2] = '{24'h400000, 8'd255, 10'd1023, 16'h0001};
        vecs[3] = '{24'h400000, 8'd255, 10'd0,    16'h8000};
        vecs[4] = '{24'h400000, 8'd127, 10'd1023, 16'hBFFF};
        vecs[5] = '{24'h400000, 8'd127, 10'd0,    16'h8000};
        vecs[6] = '{24'h400000, 8'd127, 10'd1023, 16'h4001};
        vecs[7] = '{24'h400000, 8'd127, 10'd0,    16'h8000};

        rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; fword = '0; amp = 8'd255;

        // Reset held with en toggling.
        for (int i = 0; i < 3; i++) begin
            en = ~en;
            tick();
            check("reset sample", 32'(sample), 32'h8000);
            check("reset vld", 32'(sample_vld), 32'd0);
            check("reset addr", 32'(rom_addr), 32'd0);
        end
        en = 1'b0;
        rst_n = 1'b1;
        tick();

        // Quadrant sequence and amplitude scaling.
        for (int i = 0; i < 8; i++) begin
            run_pulse($sformatf("vec%0d", i), vecs[i].fw, vecs[i].am,
                      vecs[i].exp_addr, vecs[i].exp_sample);
        end

        // Back-to-back with wrap from phase 0.
        amp = 8'd255;
        fword = 24'hFFFFFF;
        phase_clr = 1'b1; tick(); phase_clr = 1'b0;
        repeat (4) tick();
        vcount = 0; first = -1; nvld = 0;
        for (int e = 1; e <= 28; e++) begin
            en = (e <= 20);
            tick();
            if (sample_vld) begin
                vcount++;
                if (first < 0) begin
                    first = e;
                    check("b2b first sample", 32'(sample), 32'h8000);
                end
                if (e >= 5 && e <= 24) nvld++;
            end
        end
        en = 1'b0;
        check("b2b vld count", 32'(vcount), 32'd20);
        check("b2b first vld edge", 32'(first), 32'd5);
        check("b2b consecutive", 32'(nvld), 32'd20);

        // Clear mid-flight: establish a held value first.
        phase_clr = 1'b1; tick(); phase_clr = 1'b0;
        run_pulse("pre-clr", 24'h400000, 8'd127, 10'd1023, 16'hBFFF);
        fword = 24'h200000;
        amp = 8'd255;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            tick();
            check("clr no vld", 32'(sample_vld), 32'd0);
        end
        en = 1'b0;
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sample_vld) vcount++;
        end
        check("clr cancelled vld", 32'(vcount), 32'd0);
        check("clr sample held", 32'(sample), 32'hBFFF);
        run_pulse("post-clr", 24'h400000, 8'd255, 10'd1023, 16'hFFFF);

        // Reset mid-pipeline, two clocks after an en.
        fword = 24'h400000;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sample_vld) vcount++;
        end
        check("rst mid vld", 32'(vcount), 32'd0);
        check("rst mid sample", 32'(sample), 32'h8000);
        run_pulse("post-rst", 24'h400000, 8'd255, 10'd1023, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
